// File: rtl/program_loader_if.sv
// rtl/program_loader_if.sv - byte stream and program-memory write bus of the loader
interface program_loader_if #(
    parameter int WIDTH     = 32,
    parameter int ADD_WIDTH = 8
);
    logic [7:0]           byte_in;
    logic                 byte_valid;
    logic                 byte_ready;
    logic                 mem_we;
    logic [ADD_WIDTH-1:0] mem_waddr;
    logic [WIDTH-1:0]     mem_wdata;

    // Byte source side: drives the stream, observes the memory writes.
    modport master (
        output byte_in,
        output byte_valid,
        input  byte_ready,
        input  mem_we,
        input  mem_waddr,
        input  mem_wdata
    );

    // Loader side: consumes the stream, drives the memory writes.
    modport slave (
        input  byte_in,
        input  byte_valid,
        output byte_ready,
        output mem_we,
        output mem_waddr,
        output mem_wdata
    );
endinterface

// File: rtl/program_loader.sv
// rtl/program_loader.sv - assembles a byte stream into instruction words and writes program memory
module program_loader #(
    parameter int DEPTH     = 256,
    parameter int WIDTH     = 32,
    parameter int ADD_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    program_loader_if.slave      bus,
    output logic                 busy,
    output logic                 cpu_hold,
    output logic                 done,
    output logic                 overflow,
    output logic [ADD_WIDTH:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADD_WIDTH-1:0] LAST_ADDR = ADD_WIDTH'(DEPTH - 1);

    state_t               state;
    state_t               state_next;
    logic [1:0]           byte_idx;
    logic [ADD_WIDTH-1:0] waddr;
    logic [WIDTH-1:0]     wdata;
    logic                 is_halt;
    logic                 is_last;

    assign is_halt = (wdata[6:0] == 7'b1111111);
    assign is_last = (waddr == LAST_ADDR);

    // Every control output is a pure decode of the state register.
    assign bus.byte_ready = (state == LOAD);
    assign bus.mem_we     = (state == WRITE);
    assign bus.mem_waddr  = waddr;
    assign bus.mem_wdata  = wdata;
    assign busy           = (state == LOAD) || (state == WRITE);
    assign cpu_hold       = (state == LOAD) || (state == WRITE);
    assign done           = (state == DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; a word is written for exactly one cycle after its fourth byte.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = LOAD;
            LOAD:  if (bus.byte_valid && (byte_idx == 2'd3)) state_next = WRITE;
            WRITE: state_next = (is_halt || is_last) ? DONE : LOAD;
            DONE:  if (start) state_next = LOAD;
            default: state_next = IDLE;
        endcase
    end

    // Word assembly, address/count bookkeeping and the overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_idx   <= 2'd0;
            waddr      <= '0;
            wdata      <= '0;
            word_count <= '0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        byte_idx   <= 2'd0;
                        waddr      <= '0;
                        word_count <= '0;
                        overflow   <= 1'b0;
                    end
                end
                LOAD: begin
                    if (bus.byte_valid) begin
                        wdata[8*byte_idx +: 8] <= bus.byte_in;
                        byte_idx               <= byte_idx + 2'd1;
                    end
                end
                WRITE: begin
                    word_count <= word_count + (ADD_WIDTH+1)'(1);
                    if (!is_halt) begin
                        if (is_last) begin
                            overflow <= 1'b1;
                        end else begin
                            waddr <= waddr + ADD_WIDTH'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       st  [2];
    logic       vld [2];
    logic [7:0] bin [2];

    logic        rdy  [2];
    logic        we   [2];
    logic [7:0]  wa   [2];
    logic [31:0] wd   [2];
    logic        busy [2];
    logic        hold [2];
    logic        dn   [2];
    logic        ovf  [2];
    logic [8:0]  wc   [2];

    program_loader_if #(.WIDTH(32), .ADD_WIDTH(8)) bus0 ();
    program_loader_if #(.WIDTH(32), .ADD_WIDTH(8)) bus1 ();

    assign bus0.byte_in    = bin[0];
    assign bus0.byte_valid = vld[0];
    assign bus1.byte_in    = bin[1];
    assign bus1.byte_valid = vld[1];
    assign rdy[0] = bus0.byte_ready;
    assign rdy[1] = bus1.byte_ready;
    assign we[0]  = bus0.mem_we;
    assign we[1]  = bus1.mem_we;
    assign wa[0]  = bus0.mem_waddr;
    assign wa[1]  = bus1.mem_waddr;
    assign wd[0]  = bus0.mem_wdata;
    assign wd[1]  = bus1.mem_wdata;

    program_loader #(.DEPTH(256), .WIDTH(32), .ADD_WIDTH(8)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (st[0]),
        .bus        (bus0),
        .busy       (busy[0]),
        .cpu_hold   (hold[0]),
        .done       (dn[0]),
        .overflow   (ovf[0]),
        .word_count (wc[0])
    );

    program_loader #(.DEPTH(4), .WIDTH(32), .ADD_WIDTH(8)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (st[1]),
        .bus        (bus1),
        .busy       (busy[1]),
        .cpu_hold   (hold[1]),
        .done       (dn[1]),
        .overflow   (ovf[1]),
        .word_count (wc[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every observed mem_we pulse, from either instance.
    int          got_d [$];
    int          got_a [$];
    logic [31:0] got_w [$];
    int          got_c [$];

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (we[d] === 1'b1) begin
                got_d.push_back(d);
                got_a.push_back(int'(wa[d]));
                got_w.push_back(wd[d]);
                got_c.push_back(cyc);
            end
        end
    end

    task automatic clear_writes();
        got_d.delete();
        got_a.delete();
        got_w.delete();
        got_c.delete();
    endtask

    logic [7:0] stim [$];

    function automatic logic [31:0] rand_word(input bit halt);
        logic [31:0] w;
        w = $urandom;
        if (halt) w[6:0] = 7'h7f;
        else if (w[6:0] == 7'h7f) w[0] = 1'b0;
        return w;
    endfunction

    task automatic add_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) stim.push_back(w[8*k +: 8]);
    endtask

    // mode: 0 continuous valid, 1 valid every other cycle, 2 random gaps
    task automatic run_load(input int d, input int mode, input bit noise);
        int          depth;
        logic [31:0] words [$];
        int          n_exp;
        bit          exp_ovf;
        int          exp_cyc [$];
        int          idx;
        int          t;
        int          done_cyc;
        int          extra_rdy;
        bit          r;
        bit          seen_done;
        int          n;

        depth = (d == 0) ? 256 : 4;
        n_exp = 0;
        exp_ovf = 0;
        for (int i = 0; i + 3 < stim.size(); i += 4)
            words.push_back({stim[i+3], stim[i+2], stim[i+1], stim[i]});
        foreach (words[i]) begin
            n_exp++;
            if (words[i][6:0] == 7'h7f) break;
            if (n_exp == depth) begin
                exp_ovf = 1;
                break;
            end
        end

        clear_writes();
        st[d] = 1'b1;
        @(posedge clk); #1;
        st[d] = 1'b0;
        @(negedge clk);
        check("start_busy", busy[d], 1);
        check("start_hold", hold[d], 1);
        check("start_done_clr", dn[d], 0);
        check("start_ovf_clr", ovf[d], 0);
        check("start_wc_clr", wc[d], 0);

        idx = 0;
        t = 0;
        done_cyc = -1;
        seen_done = 0;
        while (1) begin
            r = rdy[d];
            if (dn[d]) begin
                seen_done = 1;
                done_cyc = cyc;
                break;
            end
            if (t >= 3000) break;
            vld[d] = (idx < stim.size()) &&
                     (mode == 0 || (mode == 1 && (t % 2) == 0) || (mode == 2 && $urandom_range(1) == 1));
            bin[d] = vld[d] ? stim[idx] : 8'($urandom);
            st[d] = noise && ($urandom_range(7) == 0);
            @(posedge clk); #1;
            if (vld[d] && r) begin
                idx++;
                if ((idx % 4) == 0) exp_cyc.push_back(cyc);
            end
            t++;
            @(negedge clk);
        end
        st[d] = 1'b0;
        check("done_reached", seen_done, 1);

        extra_rdy = 0;
        for (int i = 0; i < 6; i++) begin
            vld[d] = 1'b1;
            bin[d] = 8'($urandom);
            @(negedge clk);
            if (rdy[d] !== 1'b0) extra_rdy++;
        end
        vld[d] = 1'b0;
        check("ready_after_done", extra_rdy, 0);

        check("bytes_accepted", idx, 4 * n_exp);
        check("write_count", got_a.size(), n_exp);
        n = (got_a.size() < n_exp) ? got_a.size() : n_exp;
        for (int i = 0; i < n; i++) begin
            check("write_dut", got_d[i], d);
            check("write_addr", got_a[i], i);
            check("write_data", got_w[i], words[i]);
            if (i < exp_cyc.size()) check("write_latency", got_c[i], exp_cyc[i]);
        end
        if (got_c.size() > 0) check("done_latency", done_cyc, got_c[got_c.size()-1] + 1);
        check("word_count", wc[d], n_exp);
        check("overflow", ovf[d], exp_ovf);
        check("done_held", dn[d], 1);
        check("busy_done", busy[d], 0);
        check("hold_done", hold[d], 0);
    endtask

    task automatic check_idle(input int d);
        check("idle_ready", rdy[d], 0);
        check("idle_we", we[d], 0);
        check("idle_busy", busy[d], 0);
        check("idle_hold", hold[d], 0);
        check("idle_done", dn[d], 0);
        check("idle_ovf", ovf[d], 0);
        check("idle_wc", wc[d], 0);
        check("idle_waddr", wa[d], 0);
    endtask

    initial begin
        int nw;
        int d;

        rst = 1'b1;
        st[0] = 1'b1;  st[1] = 1'b1;
        vld[0] = 1'b1; vld[1] = 1'b1;
        bin[0] = 8'h7f; bin[1] = 8'h7f;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_writes();
        for (int i = 0; i < 2; i++) begin
            check_idle(i);
            check("reset_wdata", wd[i], 0);
        end
        #1;
        rst = 1'b0;
        st[0] = 1'b0; st[1] = 1'b0;

        // Bytes offered in IDLE must be ignored.
        repeat (4) @(negedge clk);
        check("idle_ignores_ready", rdy[0], 0);
        check("idle_no_writes", got_a.size(), 0);
        vld[0] = 1'b0; vld[1] = 1'b0;

        // Nominal program, then the same bytes under backpressure and with start noise.
        stim = '{8'h93, 8'h00, 8'h80, 8'h00, 8'h13, 8'h01, 8'h20, 8'h00, 8'h7f, 8'h00, 8'h00, 8'h00};
        run_load(0, 0, 0);
        run_load(0, 1, 0);
        run_load(0, 2, 1);

        // Memory fills before any halt; extra bytes must be refused.
        stim.delete();
        for (int i = 0; i < 5; i++) add_word(rand_word(0));
        run_load(1, 0, 0);
        run_load(1, 2, 1);

        // Reset in the middle of a word: nothing is written, a fresh load starts at 0.
        clear_writes();
        st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        vld[0] = 1'b1;
        bin[0] = 8'haa;
        @(posedge clk); #1;
        bin[0] = 8'hbb;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        vld[0] = 1'b0;
        @(negedge clk);
        check_idle(0);
        check("midreset_no_write", got_a.size(), 0);
        stim.delete();
        add_word(rand_word(1));
        run_load(0, 0, 0);

        // Randomized programs on both instances.
        for (int it = 0; it < 12; it++) begin
            d = $urandom_range(1);
            nw = $urandom_range(1, 7);
            stim.delete();
            for (int i = 0; i < nw; i++) begin
                if (i == nw - 1) add_word(rand_word((d == 0) || (nw < 4) || ($urandom_range(1) == 1)));
                else add_word(rand_word($urandom_range(15) == 0));
            end
            run_load(d, $urandom_range(2), $urandom_range(1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
